// File: rtl/imem_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl_pkg
//   Shared definitions for the instruction-memory load controller: controller
//   state encoding, ROM geometry defaults and the partial-word justification
//   helper used when a load ends mid-word.
// ---------------------------------------------------------------------------
package imem_load_ctrl_pkg;

    localparam int ROM_ADDR_W     = 14;   // word address width (PC[15:2])
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int CNT_W          = 3;    // holds 0..BYTES_PER_WORD

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,   // CPU owns the ROM port
        ST_LOAD  = 2'd1,   // UART bytes are packed and written
        ST_FLUSH = 2'd2,   // write the trailing partial word
        ST_DONE  = 2'd3    // one-cycle completion, CPU still held
    } load_state_t;

    // Bytes enter at the LSB end, so a partial word must be shifted up to put
    // the first received byte in the MSB; unused low bytes read as zero.
    function automatic logic [WORD_W-1:0] left_justify(
        input logic [WORD_W-1:0] shift,
        input logic [CNT_W-1:0]  cnt
    );
        logic [WORD_W-1:0] w;
        case (cnt)
            3'd1:    w = {shift[7:0],  24'h00_0000};
            3'd2:    w = {shift[15:0], 16'h0000};
            3'd3:    w = {shift[23:0], 8'h00};
            default: w = shift;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl_byte_packer
//   Shift register plus byte counter that assembles UART bytes into 32-bit
//   words, first byte in the MSB.
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   clear          start of a new load: drop any buffered bytes
//   accept         rx_byte is taken this cycle
//   consume        the buffered word is written this cycle (byte_cnt -> 0)
//   rx_byte        incoming byte
//   word_ready     four bytes buffered
//   flush_needed   bytes will remain buffered after this cycle's accept/consume
//   word           full buffered word
//   flush_word     buffered bytes left-justified, zero-filled below
// ---------------------------------------------------------------------------
module imem_load_ctrl_byte_packer
    import imem_load_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              consume,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              word_ready,
    output logic              flush_needed,
    output logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] flush_word
);

    logic [WORD_W-1:0] shift;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  cnt_base;

    // A write and a new byte can land in the same cycle: the write empties the
    // counter first, then the new byte becomes byte 1 of the next word.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        cnt_base = byte_cnt;
        if (consume) begin
            cnt_base = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            shift    <= {shift[WORD_W-BYTE_W-1:0], rx_byte};
            byte_cnt <= cnt_base + CNT_W'(1);
        end else begin
            byte_cnt <= cnt_base;
        end
    end

    assign word_ready   = (byte_cnt == CNT_W'(BYTES_PER_WORD));
    assign flush_needed = accept || (cnt_base != '0);
    assign word         = shift;
    assign flush_word   = left_justify(shift, byte_cnt);

endmodule

// File: rtl/imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// imem_load_ctrl
//   Owns the program ROM port and shares it between CPU instruction fetch and
//   a UART byte-stream loader. During a load the CPU is held in reset and
//   packed words are written to consecutive word addresses from 0; when the
//   load ends the CPU is released and fetch restarts at PC=0.
// Ports
//   clock, reset   system clock, synchronous active-high reset
//   load_req       level, 1 = loader mode requested
//   rx_valid       one-cycle strobe qualifying rx_byte
//   rx_byte        received byte
//   fetch_addr     CPU fetch word address
//   mem_we         ROM write enable
//   mem_addr       ROM address: fetch_addr in RUN, write pointer otherwise
//   mem_wdata      ROM write data
//   cpu_hold       CPU reset, 1 = CPU held at PC=0
//   load_busy      1 in LOAD and FLUSH
//   load_done      one-cycle pulse as a load completes
//   word_count     words written by the last or current load (saturating)
//   overflow       sticky: a word was dropped because the ROM was full
// ---------------------------------------------------------------------------
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = WORD_W        // must stay 32: four bytes per word
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow
);

    load_state_t       state;
    // One extra bit: wptr reaches 2^ADDR_W when the ROM is full and stays
    // there, which is exactly the saturating word count.
    logic [ADDR_W:0]   wptr;
    logic              full;
    logic              accept;
    logic              write_req;
    logic              start_load;
    logic              word_ready;
    logic              flush_needed;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] flush_word;

    assign full       = wptr[ADDR_W];
    assign start_load = (state == ST_RUN) && load_req;
    assign accept     = (state == ST_LOAD) && rx_valid;
    assign write_req  = ((state == ST_LOAD) && word_ready) || (state == ST_FLUSH);

    imem_load_ctrl_byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_load),
        .accept       (accept),
        .consume      (write_req),
        .rx_byte      (rx_byte),
        .word_ready   (word_ready),
        .flush_needed (flush_needed),
        .word         (word),
        .flush_word   (flush_word)
    );

    // The write strobe is gated by reset so a word that completes just as
    // reset arrives is not committed; the partial image already in the ROM
    // is left alone.
    assign mem_we     = write_req && !full && !reset;
    assign mem_addr   = (state == ST_RUN) ? fetch_addr : wptr[ADDR_W-1:0];
    assign mem_wdata  = (state == ST_FLUSH) ? flush_word : word;
    assign word_count = wptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the block order does not matter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            wptr      <= '0;
            overflow  <= 1'b0;
            cpu_hold  <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;

            // Writes never happen in RUN, so this cannot collide with the
            // pointer clear on load start below.
            if (write_req) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    wptr <= wptr + (ADDR_W+1)'(1);
                end
            end

            case (state)
                ST_RUN: begin
                    if (load_req) begin
                        state     <= ST_LOAD;
                        wptr      <= '0;
                        overflow  <= 1'b0;
                        cpu_hold  <= 1'b1;
                        load_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // flush_needed already accounts for a byte strobed in the
                    // same cycle load_req falls.
                    if (!load_req) begin
                        if (flush_needed) begin
                            state <= ST_FLUSH;
                        end else begin
                            state     <= ST_DONE;
                            load_busy <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_DONE;
                    load_busy <= 1'b0;
                    load_done <= 1'b1;
                end
                ST_DONE: begin
                    state    <= ST_RUN;
                    cpu_hold <= 1'b0;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule
